pe_psum_accumulator: RTL

Consumer-side companion to the PE psum FIFO. It drains incoming partial sums from the FIFO's ready/valid output into a local psum scratchpad, or zero-initialises the scratchpad. It then accumulates a stream of MAC results into the scratchpad over a configured number of rounds and finally streams the updated psums out on a ready/valid port toward the next PE or the GLB. It sits inside each PE between the psum input FIFO, the MAC datapath and the psum output FIFO.

---
 rtl/pe_psum_pkg.sv | 15 +
 rtl/pe_psum_accumulator_if.sv | 37 +++
 rtl/psum_sat_add.sv | 25 ++
 rtl/pe_psum_accumulator.sv | 133 +++++++++++++
 4 files changed

// File: rtl/pe_psum_pkg.sv
// Shared types and constants for the PE psum accumulation path.
package pe_psum_pkg;

    localparam int PSUM_W = 21;
    localparam logic signed [PSUM_W-1:0] PSUM_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic signed [PSUM_W-1:0] PSUM_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ACCUM = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/pe_psum_accumulator_if.sv
// Config, psum-in, MAC-in and psum-out handshake bundle of the psum accumulator.
interface pe_psum_accumulator_if #(
    parameter int PSUM_W     = 21,
    parameter int PSUM_DEPTH = 16,
    parameter int ROUND_W    = 8
);
    localparam int IDX_W = $clog2(PSUM_DEPTH);

    logic                     cfg_valid;
    logic                     cfg_ready;
    logic [IDX_W-1:0]         cfg_num_psum_m1;
    logic [ROUND_W-1:0]       cfg_num_round;
    logic                     cfg_load_psum;
    logic                     psum_in_valid;
    logic                     psum_in_ready;
    logic signed [PSUM_W-1:0] psum_in_data;
    logic                     mac_in_valid;
    logic                     mac_in_ready;
    logic signed [PSUM_W-1:0] mac_in_data;
    logic                     psum_out_valid;
    logic                     psum_out_ready;
    logic signed [PSUM_W-1:0] psum_out_data;
    logic                     done;

    modport slave (
        input  cfg_valid, cfg_num_psum_m1, cfg_num_round, cfg_load_psum,
        input  psum_in_valid, psum_in_data, mac_in_valid, mac_in_data, psum_out_ready,
        output cfg_ready, psum_in_ready, mac_in_ready, psum_out_valid, psum_out_data, done
    );

    modport master (
        output cfg_valid, cfg_num_psum_m1, cfg_num_round, cfg_load_psum,
        output psum_in_valid, psum_in_data, mac_in_valid, mac_in_data, psum_out_ready,
        input  cfg_ready, psum_in_ready, mac_in_ready, psum_out_valid, psum_out_data, done
    );

endinterface

// File: rtl/psum_sat_add.sv
// Combinational signed saturating adder at PSUM_W bits.
module psum_sat_add #(
    parameter int PSUM_W = 21
) (
    input  logic signed [PSUM_W-1:0] a,
    input  logic signed [PSUM_W-1:0] b,
    output logic signed [PSUM_W-1:0] sum
);
    localparam logic [PSUM_W-1:0] SAT_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic [PSUM_W-1:0] SAT_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

    logic [PSUM_W:0] wide;

    assign wide = {a[PSUM_W-1], a} + {b[PSUM_W-1], b};

    // Overflow when the extra sign bit disagrees with the result's sign bit.
    always_comb begin
        if (wide[PSUM_W] != wide[PSUM_W-1]) begin
            sum = wide[PSUM_W] ? SAT_MIN : SAT_MAX;
        end else begin
            sum = wide[PSUM_W-1:0];
        end
    end

endmodule

// File: rtl/pe_psum_accumulator.sv
// Loads or zero-fills a psum scratchpad, accumulates MAC results over rounds, then drains it.
module pe_psum_accumulator #(
    parameter int PSUM_W     = 21,
    parameter int PSUM_DEPTH = 16,
    parameter int ROUND_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pe_psum_accumulator_if.slave   bus
);
    import pe_psum_pkg::*;

    localparam int IDX_W = $clog2(PSUM_DEPTH);

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d, num_m1_q;
    logic [ROUND_W-1:0]       round_q, round_d, num_round_q;
    logic                     load_q;
    logic                     done_q, done_d;
    logic signed [PSUM_W-1:0] spad [PSUM_DEPTH];
    logic                     wr_en;
    logic signed [PSUM_W-1:0] wr_data, rd_data, acc_sum;
    logic                     idx_last, round_last;

    assign rd_data    = spad[idx_q];
    assign idx_last   = (idx_q == num_m1_q);
    assign round_last = (round_q == num_round_q - ROUND_W'(1));

    psum_sat_add #(.PSUM_W(PSUM_W)) u_sat_add (
        .a   (rd_data),
        .b   (bus.mac_in_data),
        .sum (acc_sum)
    );

    assign bus.cfg_ready      = (state_q == IDLE);
    assign bus.psum_in_ready  = (state_q == INIT) && load_q;
    assign bus.mac_in_ready   = (state_q == ACCUM);
    assign bus.psum_out_valid = (state_q == DRAIN);
    assign bus.psum_out_data  = rd_data;
    assign bus.done           = done_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        round_d = round_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    state_d = INIT;
                    idx_d   = '0;
                    round_d = '0;
                end
            end
            INIT: begin
                wr_en   = load_q ? bus.psum_in_valid : 1'b1;
                wr_data = load_q ? bus.psum_in_data : '0;
                if (wr_en) begin
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = (num_round_q == '0) ? DRAIN : ACCUM;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ACCUM: begin
                wr_en   = bus.mac_in_valid;
                wr_data = acc_sum;
                if (wr_en) begin
                    if (idx_last) begin
                        idx_d = '0;
                        if (round_last) begin
                            round_d = '0;
                            state_d = DRAIN;
                        end else begin
                            round_d = round_q + ROUND_W'(1);
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (bus.psum_out_ready) begin
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            round_q     <= '0;
            num_m1_q    <= '0;
            num_round_q <= '0;
            load_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            round_q <= round_d;
            done_q  <= done_d;
            if (state_q == IDLE && bus.cfg_valid) begin
                num_m1_q    <= bus.cfg_num_psum_m1;
                num_round_q <= bus.cfg_num_round;
                load_q      <= bus.cfg_load_psum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PSUM_DEPTH; i++) begin
                spad[i] <= '0;
            end
        end else if (wr_en) begin
            spad[idx_q] <= wr_data;
        end
    end

endmodule
